// File: rtl/mips_isa_pkg.sv
// Shared MIPS encoding constants: instruction classes, opcodes, FIFO sizing
// and the word-formatting helpers used by instr_encoder_mips.
package mips_isa_pkg;

   typedef enum logic [2:0] {
      KIND_R    = 3'd0,
      KIND_ADDI = 3'd1,
      KIND_LW   = 3'd2,
      KIND_SW   = 3'd3,
      KIND_BEQ  = 3'd4,
      KIND_J    = 3'd5
   } kind_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wr_state_e;

   localparam logic [5:0] OP_RALU = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam int WORD_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

   // Codes 6 and 7 have no instruction class.
   function automatic logic kind_is_valid(input logic [2:0] kind);
      return kind <= KIND_J;
   endfunction

   function automatic logic [WORD_W-1:0] encode_word(
      input logic [2:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      case (kind)
         KIND_R:    return {OP_RALU, rs, rt, rd, 5'b00000, funct};
         KIND_ADDI: return {OP_ADDI, rs, rt, imm};
         KIND_LW:   return {OP_LW, rs, rt, imm};
         KIND_SW:   return {OP_SW, rs, rt, imm};
         KIND_BEQ:  return {OP_BEQ, rs, rt, imm};
         KIND_J:    return {OP_J, target};
         default:   return '0;
      endcase
   endfunction

endpackage

// File: rtl/instr_fifo_mips.sv
// Parameterised synchronous FIFO with occupancy count; rdata reads as zero
// while empty so the head can drive an output bus directly.
module instr_fifo_mips #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; the pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder_mips.sv
// MIPS instruction encoder: requests are encoded, queued, and written to
// instruction memory. Define INSTR_ENC_DEST_CHECK_EN to reject zero destinations.
module instr_encoder_mips
   import mips_isa_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [2:0]          i_kind,
   input  logic [4:0]          i_rs,
   input  logic [4:0]          i_rt,
   input  logic [4:0]          i_rd,
   input  logic [5:0]          i_funct,
   input  logic [15:0]         i_imm,
   input  logic [25:0]         i_target,
   input  logic                i_base_load,
   input  logic [7:0]          i_base_addr,
   output logic                o_mem_we,
   output logic [7:0]          o_mem_addr,
   output logic [WORD_W-1:0]   o_mem_wdata,
   input  logic                i_mem_ack,
   output logic                o_err,
   output logic                o_wrapped,
   output logic                o_busy
);

   wr_state_e             state;
   logic [7:0]            addr;
   logic [WORD_W-1:0]     enc_word;
   logic [FIFO_CNT_W-1:0] count;
   logic                  legal;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;

   // NOTE: legal gets its default before any override so no latch is inferred.
   always_comb begin
      legal = kind_is_valid(i_kind);
`ifdef INSTR_ENC_DEST_CHECK_EN
      if (i_kind == KIND_R && i_rd == 5'd0) legal = 1'b0;
      if ((i_kind == KIND_ADDI || i_kind == KIND_LW) && i_rt == 5'd0) legal = 1'b0;
`endif
   end

   assign enc_word = encode_word(i_kind, i_rs, i_rt, i_rd, i_funct, i_imm, i_target);
   assign o_ready  = !full;
   assign accept   = i_valid && o_ready;
   assign push     = accept && legal;
   assign pop      = (state == ST_WRITE) && i_mem_ack;

   instr_fifo_mips #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .push  (push),
      .pop   (pop),
      .wdata (enc_word),
      .rdata (o_mem_wdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign o_mem_addr = addr;
   assign o_busy     = !empty;

   // NOTE: all state updates use <= so every branch sees pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         o_mem_we  <= 1'b0;
         addr      <= 8'h00;
         o_err     <= 1'b0;
         o_wrapped <= 1'b0;
      end else begin
         if (accept && !legal) o_err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (i_base_load && empty) addr <= i_base_addr;
               // Entering WRITE on the push itself gives single-cycle latency.
               if (push || !empty) begin
                  state    <= ST_WRITE;
                  o_mem_we <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (i_mem_ack) begin
                  addr <= addr + 8'd1;
                  if (addr == 8'hFF) o_wrapped <= 1'b1;
                  if (count == FIFO_CNT_W'(1) && !push) begin
                     state    <= ST_IDLE;
                     o_mem_we <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               o_mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_mips.sv
// Self-checking bench for instr_encoder_mips: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_instr_encoder_mips;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_kind = '0;
   logic [4:0]  i_rs = '0, i_rt = '0, i_rd = '0;
   logic [5:0]  i_funct = '0;
   logic [15:0] i_imm = '0;
   logic [25:0] i_target = '0;
   logic        i_base_load = 1'b0;
   logic [7:0]  i_base_addr = '0;
   logic        o_mem_we;
   logic [7:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack = 1'b0;
   logic        o_err, o_wrapped, o_busy;

   int checks = 0;
   int failures = 0;

   // Behavioural model: queued words, write address and sticky flags.
   logic [31:0] m_q[$];
   int          m_addr = 0;
   bit          m_err = 0;
   bit          m_wrapped = 0;

   instr_encoder_mips dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_kind(i_kind), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_funct(i_funct),
      .i_imm(i_imm), .i_target(i_target), .i_base_load(i_base_load),
      .i_base_addr(i_base_addr), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .o_err(o_err),
      .o_wrapped(o_wrapped), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] ref_encode(int kind, int rs, int rt, int rd,
                                              int funct, int imm, int target);
      int unsigned op;
      int unsigned rs_u = rs, rt_u = rt, rd_u = rd;
      if (kind == 0) return 32'(rs_u * 2097152 + rt_u * 65536 + rd_u * 2048 + funct);
      if (kind == 5) return 32'(2 * 67108864 + target);
      case (kind)
         1: op = 8;
         2: op = 35;
         3: op = 43;
         default: op = 4;
      endcase
      return 32'(op * 67108864 + rs_u * 2097152 + rt_u * 65536 + imm);
   endfunction

   function automatic bit ref_legal(int kind, int rt, int rd);
      bit dest_zero = (kind == 0 && rd == 0) || ((kind == 1 || kind == 2) && rt == 0);
      if (kind > 5) return 0;
`ifdef INSTR_ENC_DEST_CHECK_EN
      if (dest_zero) return 0;
`else
      if (dest_zero) return 1;
`endif
      return 1;
   endfunction

   task automatic idle_inputs();
      i_valid = 0; i_kind = 0; i_rs = 0; i_rt = 0; i_rd = 0; i_funct = 0;
      i_imm = 0; i_target = 0; i_base_load = 0; i_base_addr = 0; i_mem_ack = 0;
   endtask

   task automatic set_req(int kind, int rs, int rt, int rd, int funct, int imm, int target);
      i_valid = 1; i_kind = 3'(kind); i_rs = 5'(rs); i_rt = 5'(rt); i_rd = 5'(rd);
      i_funct = 6'(funct); i_imm = 16'(imm); i_target = 26'(target);
   endtask

   // Advance one clock, updating the model from the inputs presented this cycle.
   task automatic tick();
      bit acc, ack_eff, bl_eff;
      acc     = i_valid && (m_q.size() < 4);
      ack_eff = i_mem_ack && (m_q.size() > 0);
      bl_eff  = i_base_load && (m_q.size() == 0);
      if (ack_eff) begin
         void'(m_q.pop_front());
         if (m_addr == 255) m_wrapped = 1;
         m_addr = (m_addr + 1) % 256;
      end
      if (acc) begin
         if (ref_legal(int'(i_kind), int'(i_rt), int'(i_rd)))
            m_q.push_back(ref_encode(int'(i_kind), int'(i_rs), int'(i_rt), int'(i_rd),
                                     int'(i_funct), int'(i_imm), int'(i_target)));
         else
            m_err = 1;
      end
      if (bl_eff) m_addr = int'(i_base_addr);
      @(posedge i_clk);
      #1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      i_reset_n = 0;
      m_q.delete(); m_addr = 0; m_err = 0; m_wrapped = 0;
      @(posedge i_clk);
      #3 i_reset_n = 1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 i_reset_n = 0;
      #1;
      checks++;
      if ({o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_wrapped, o_busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: we=%b addr=%h wdata=%h err=%b wrap=%b busy=%b, want all 0",
                  o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_wrapped, o_busy);
      end
      apply_reset();
      checks++;
      if (o_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b want 1", o_ready);
      end
   endtask

   task automatic test_r_alu();
      apply_reset();
      set_req(0, 1, 2, 3, 'h20, 0, 0);
      tick();
      i_valid = 0;
      checks++;
      if (o_mem_we !== 1'b1 || o_mem_addr !== 8'h00 || o_mem_wdata !== 32'h0022_1820) begin
         failures++;
         $display("FAIL r_alu_write: we=%b addr=%h wdata=%h, want 1 00 00221820",
                  o_mem_we, o_mem_addr, o_mem_wdata);
      end
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
      checks++;
      if (o_mem_we !== 1'b0 || o_mem_addr !== 8'h01 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL r_alu_ack: we=%b addr=%h busy=%b, want 0 01 0",
                  o_mem_we, o_mem_addr, o_busy);
      end
      // Ack while idle must leave the address alone.
      i_mem_ack = 1;
      tick(); tick();
      i_mem_ack = 0;
      checks++;
      if (o_mem_addr !== 8'h01 || o_mem_we !== 1'b0) begin
         failures++;
         $display("FAIL ack_in_idle: addr=%h we=%b, want 01 0", o_mem_addr, o_mem_we);
      end
   endtask

   task automatic test_beq_sw();
      apply_reset();
      set_req(4, 4, 5, 0, 0, 'hFFFE, 0);
      tick();
      set_req(3, 29, 31, 0, 0, 4, 0);
      tick();
      i_valid = 0;
      checks++;
      if (o_mem_wdata !== 32'h1085_FFFE || o_mem_addr !== 8'h00) begin
         failures++;
         $display("FAIL beq_word: wdata=%h addr=%h, want 1085fffe 00", o_mem_wdata, o_mem_addr);
      end
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
      checks++;
      if (o_mem_wdata !== 32'hAFBF_0004 || o_mem_addr !== 8'h01 || o_mem_we !== 1'b1) begin
         failures++;
         $display("FAIL sw_word: wdata=%h addr=%h we=%b, want afbf0004 01 1",
                  o_mem_wdata, o_mem_addr, o_mem_we);
      end
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] first_word;
      logic [31:0] fifth_word;
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         set_req(1, $urandom_range(0, 31), $urandom_range(1, 31), 0, 0, $urandom_range(0, 65535), 0);
         tick();
      end
      first_word = m_q[0];
      checks++;
      if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL full_after_4: ready=%b busy=%b, want 0 1", o_ready, o_busy);
      end
      set_req(3, 7, 9, 0, 0, 'h1234, 0);
      fifth_word = ref_encode(3, 7, 9, 0, 0, 'h1234, 0);
      tick();
      checks++;
      if (o_ready !== 1'b0 || o_mem_wdata !== first_word || m_q.size() != 4) begin
         failures++;
         $display("FAIL fifth_held: ready=%b wdata=%h, want 0 %h", o_ready, o_mem_wdata, first_word);
      end
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
      checks++;
      if (o_ready !== 1'b1 || o_mem_addr !== 8'h01) begin
         failures++;
         $display("FAIL ack_frees_slot: ready=%b addr=%h, want 1 01", o_ready, o_mem_addr);
      end
      tick();
      i_valid = 0;
      checks++;
      if (o_ready !== 1'b0 || m_q[m_q.size()-1] !== fifth_word) begin
         failures++;
         $display("FAIL fifth_accepted: ready=%b, want 0", o_ready);
      end
      for (int n = 0; n < 4; n++) begin
         checks++;
         if (o_mem_we !== 1'b1 || o_mem_wdata !== m_q[0] || o_mem_addr !== 8'(m_addr)) begin
            failures++;
            $display("FAIL drain_%0d: we=%b wdata=%h addr=%h, want 1 %h %h",
                     n, o_mem_we, o_mem_wdata, o_mem_addr, m_q[0], 8'(m_addr));
         end
         i_mem_ack = 1;
         tick();
         i_mem_ack = 0;
      end
      checks++;
      if (o_mem_we !== 1'b0 || o_mem_addr !== 8'h05) begin
         failures++;
         $display("FAIL drain_done: we=%b addr=%h, want 0 05", o_mem_we, o_mem_addr);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      i_base_load = 1; i_base_addr = 8'hFF;
      tick();
      i_base_load = 0;
      set_req(5, 0, 0, 0, 0, 0, 'h10);
      tick(); tick();
      i_valid = 0;
      i_base_load = 1; i_base_addr = 8'h40;
      tick();
      i_base_load = 0;
      checks++;
      if (o_mem_we !== 1'b1 || o_mem_addr !== 8'hFF || o_mem_wdata !== 32'h0800_0010) begin
         failures++;
         $display("FAIL wrap_first: we=%b addr=%h wdata=%h, want 1 ff 08000010",
                  o_mem_we, o_mem_addr, o_mem_wdata);
      end
      i_mem_ack = 1;
      tick();
      checks++;
      if (o_mem_addr !== 8'h00 || o_mem_wdata !== 32'h0800_0010 || o_wrapped !== 1'b1) begin
         failures++;
         $display("FAIL wrap_second: addr=%h wdata=%h wrapped=%b, want 00 08000010 1",
                  o_mem_addr, o_mem_wdata, o_wrapped);
      end
      tick();
      i_mem_ack = 0;
      checks++;
      if (o_mem_we !== 1'b0 || o_wrapped !== 1'b1 || o_mem_addr !== 8'h01) begin
         failures++;
         $display("FAIL wrap_sticky: we=%b wrapped=%b addr=%h, want 0 1 01",
                  o_mem_we, o_wrapped, o_mem_addr);
      end
   endtask

   task automatic test_illegal();
      apply_reset();
      set_req(7, 1, 2, 3, 4, 5, 6);
      tick();
      i_valid = 0;
      tick(); tick();
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_mem_we !== 1'b0) begin
         failures++;
         $display("FAIL illegal_kind: err=%b busy=%b we=%b, want 1 0 0", o_err, o_busy, o_mem_we);
      end
      apply_reset();
      checks++;
      if (o_err !== 1'b0) begin
         failures++;
         $display("FAIL err_cleared: err=%b want 0", o_err);
      end
      set_req(1, 3, 0, 0, 0, 5, 0);
      tick();
      i_valid = 0;
`ifdef INSTR_ENC_DEST_CHECK_EN
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL addi_rt0_illegal: err=%b busy=%b, want 1 0", o_err, o_busy);
      end
`else
      checks++;
      if (o_err !== 1'b0 || o_mem_we !== 1'b1 || o_mem_wdata !== 32'h2060_0005) begin
         failures++;
         $display("FAIL addi_rt0_legal: err=%b we=%b wdata=%h, want 0 1 20600005",
                  o_err, o_mem_we, o_mem_wdata);
      end
`endif
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
   endtask

   task automatic test_reset_mid_write();
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         set_req(5, 0, 0, 0, 0, $urandom_range(0, 1023), n + 1);
         tick();
      end
      i_valid = 0;
      i_mem_ack = 1;
      tick();
      i_mem_ack = 0;
      checks++;
      if (o_mem_we !== 1'b1 || o_mem_addr !== 8'h01 || m_q.size() != 3) begin
         failures++;
         $display("FAIL pre_reset_write: we=%b addr=%h, want 1 01", o_mem_we, o_mem_addr);
      end
      #2 i_reset_n = 0;
      #1;
      checks++;
      if ({o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_wrapped, o_busy} !== '0) begin
         failures++;
         $display("FAIL async_reset_mid_write: we=%b addr=%h wdata=%h err=%b wrap=%b busy=%b, want all 0",
                  o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_wrapped, o_busy);
      end
      m_q.delete(); m_addr = 0; m_err = 0; m_wrapped = 0;
      @(posedge i_clk);
      #3 i_reset_n = 1;
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_mem_we !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_empty: busy=%b we=%b ready=%b, want 0 0 1",
                  o_busy, o_mem_we, o_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_wdata;
      int r;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 15);
         set_req((r < 14) ? (r % 6) : (6 + r % 2), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                 $urandom_range(0, 1 << 20));
         i_valid     = ($urandom_range(0, 3) != 0);
         i_mem_ack   = ($urandom_range(0, 2) == 0);
         i_base_load = ($urandom_range(0, 7) == 0);
         i_base_addr = 8'($urandom_range(240, 255));
         tick();
         exp_wdata = 32'h0;
         if (m_q.size() > 0) exp_wdata = m_q[0];
         checks++;
         if (o_mem_we !== (m_q.size() > 0) || o_busy !== (m_q.size() > 0) ||
             o_ready !== (m_q.size() < 4) || o_mem_addr !== 8'(m_addr) ||
             o_mem_wdata !== exp_wdata || o_err !== m_err || o_wrapped !== m_wrapped) begin
            failures++;
            $display("FAIL random_%0d: we=%b ready=%b addr=%h wdata=%h err=%b wrap=%b want we=%b ready=%b addr=%h wdata=%h err=%b wrap=%b",
                     n, o_mem_we, o_ready, o_mem_addr, o_mem_wdata, o_err, o_wrapped,
                     m_q.size() > 0, m_q.size() < 4, 8'(m_addr), exp_wdata, m_err, m_wrapped);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_r_alu();
      test_beq_sw();
      test_back_to_back();
      test_wrap();
      test_illegal();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder_mips.md
INSTR_ENCODER_MIPS -- requirements
Module: instr_encoder_mips

Interface
REQ-001 SHALL have port i_clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_valid, input, 1, encode request valid.
REQ-004 SHALL have port o_ready, output, 1, request accepted when i_valid && o_ready at clock edge.
REQ-005 SHALL have port i_kind, input, 3, instruction class: 0 R-ALU, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J; 6-7 illegal.
REQ-006 SHALL have ports i_rs, i_rt, i_rd, input, 5 each, register fields.
REQ-007 SHALL have ports i_funct (6), i_imm (16) and i_target (26), all inputs, carrying R funct, I immediate and J target.
REQ-008 SHALL have ports i_base_load (input, 1) and i_base_addr (input, 8), which load the write word-address.
REQ-009 SHALL have ports o_mem_we (output, 1), o_mem_addr (output, 8), o_mem_wdata (output, 32) and i_mem_ack (input, 1), forming the instruction-memory write port.
REQ-010 SHALL have ports o_err (output, 1, sticky illegal-request flag), o_wrapped (output, 1, sticky address-wrap flag) and o_busy (output, 1, FIFO non-empty).

Function
REQ-011 SHALL encode R-ALU as {6'b000000, rs, rt, rd, 5'b00000, funct}.
REQ-012 SHALL encode ADDI/LW/SW/BEQ as {op, rs, rt, imm}, with op 001000/100011/101011/000100.
REQ-013 SHALL encode J as {6'b000010, target}.
REQ-014 SHALL push each accepted, legal, encoded word into a 4-entry FIFO; o_ready = FIFO not full.
REQ-015 SHALL NOT enqueue an accepted illegal i_kind; it SHALL set o_err one cycle after acceptance.
REQ-016 SHALL use a writer FSM with states IDLE and WRITE: IDLE->WRITE when FIFO is non-empty; WRITE->IDLE on i_mem_ack when that ack empties the FIFO.
REQ-017 SHALL, in WRITE, assert o_mem_we with o_mem_wdata = FIFO head and o_mem_addr = current address, held stable until i_mem_ack.
REQ-018 SHALL, on i_mem_ack in WRITE, pop the head and increment the address modulo 256; on 255->0 it SHALL set o_wrapped.
REQ-019 SHALL give minimum latency of one cycle from acceptance to o_mem_we for that word when the FIFO was empty.
REQ-020 SHALL give simultaneous push and ack on a non-full FIFO a net occupancy change of 0; when the FIFO is full, o_ready is low and no push occurs even if an ack frees a slot that cycle.
REQ-021 SHALL ignore i_mem_ack in IDLE.
REQ-022 SHALL load i_base_addr on i_base_load only in IDLE with the FIFO empty; otherwise i_base_load is ignored.

Reset
REQ-023 SHALL, on reset assertion, asynchronously clear the FIFO and set state IDLE, address 0, o_mem_we 0, o_mem_wdata 0, o_err 0, o_wrapped 0 and o_busy 0; o_ready SHALL be 1 after release.
REQ-024 SHALL discard an in-flight write without ack when reset is asserted mid-WRITE.

Configuration
REQ-025 SHALL, with INSTR_ENC_DEST_CHECK_EN defined, treat R-ALU with rd=0 and ADDI/LW with rt=0 as illegal (REQ-015 applies); without the macro, these requests are legal and encoded normally.

Structure
REQ-026 SHALL take i_kind codes, the six opcode constants and the FIFO depth from shared package mips_isa_pkg.
REQ-027 SHALL implement the FIFO as sub-module instr_fifo_mips (parameterised width/depth, full/empty outputs).

Verification
REQ-028 SHALL cover: reset, then R-ALU rs=1 rt=2 rd=3 funct=0x20 -> next cycle o_mem_we=1, addr 0x00, wdata 0x00221820.
REQ-029 SHALL cover: five back-to-back requests with i_mem_ack held 0 -> o_ready=0 after the 4th, the 5th is held; ack for 1 cycle -> the 5th is accepted the following cycle.
REQ-030 SHALL cover: i_base_load with addr 0xFF, then two J target 0x0000010 words -> writes 0x08000010 at 0xFF then at 0x00, and o_wrapped=1.
REQ-031 SHALL cover: i_kind=7 -> nothing written and o_err=1 until reset; with INSTR_ENC_DEST_CHECK_EN, ADDI rt=0 -> o_err=1.
REQ-032 SHALL cover: i_reset_n low while o_mem_we=1 with 3 words queued -> all outputs at reset values immediately and FIFO empty after release.
REQ-033 SHALL cover: BEQ rs=4 rt=5 imm=0xFFFE -> wdata 0x1085FFFE; SW rs=29 rt=31 imm=4 -> 0xAFBF0004.
